// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit.
// Access-size codes and FSM state values.
package load_store_unit_pkg;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;
  localparam logic [1:0] LEN_D = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int CNT_W = 5;

  function automatic logic is_misaligned(
    input logic [1:0] len,
    input logic [2:0] lo
  );
    logic m;
    m = 1'b0;
    case (len)
      LEN_H:   m = lo[0];
      LEN_W:   m = |lo[1:0];
      LEN_D:   m = |lo;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_merge.sv
// Byte-lane extract/extend for loads and
// lane merge for sub-dword stores.
module lane_merge
  import load_store_unit_pkg::*;
(
  input  logic [63:0] rd,
  input  logic [63:0] wd,
  input  logic [2:0]  off,
  input  logic [1:0]  len,
  input  logic        sgn,
  output logic [63:0] ext,
  output logic [63:0] merged
);

  logic [5:0]  sh;
  logic [63:0] shifted;
  logic [63:0] mask;

  // Shift the addressed lane down, extend it, and splice store bytes in
  always_comb begin
    sh      = {off, 3'b000};
    shifted = rd >> sh;
    mask    = '0;
    ext     = '0;
    unique case (len)
      LEN_B: begin
        mask = 64'h0000_0000_0000_00FF;
        ext  = {{56{sgn & shifted[7]}}, shifted[7:0]};
      end
      LEN_H: begin
        mask = 64'h0000_0000_0000_FFFF;
        ext  = {{48{sgn & shifted[15]}}, shifted[15:0]};
      end
      LEN_W: begin
        mask = 64'h0000_0000_FFFF_FFFF;
        ext  = {{32{sgn & shifted[31]}}, shifted[31:0]};
      end
      LEN_D: begin
        mask = '1;
        ext  = shifted;
      end
    endcase
    merged = (rd & ~(mask << sh)) | ((wd & mask) << sh);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: core request to dword data bus,
// with lane extraction and read-modify-write stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int BUS_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_len,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_exception,
  output logic        resp_misaligned,
  output logic        bus_rw,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_write,
  input  logic [63:0] bus_read,
  input  logic        bus_exception
);

  logic [1:0]       state;
  logic             rw_q;
  logic [1:0]       len_q;
  logic             sgn_q;
  logic [2:0]       off_q;
  logic [63:0]      wdata_q;
  logic [63:0]      data_q;
  logic             exc_q;
  logic             mis_q;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      ld_ext;
  logic [63:0]      st_merged;

  lane_merge u_lane (
    .rd     (bus_read),
    .wd     (wdata_q),
    .off    (off_q),
    .len    (len_q),
    .sgn    (sgn_q),
    .ext    (ld_ext),
    .merged (st_merged)
  );

  // Request capture, bus sequencing and response staging
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rw_q     <= 1'b0;
      len_q    <= LEN_B;
      sgn_q    <= 1'b0;
      off_q    <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      exc_q    <= 1'b0;
      mis_q    <= 1'b0;
      cnt      <= '0;
      bus_addr <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            rw_q    <= req_rw;
            len_q   <= req_len;
            sgn_q   <= req_signed;
            off_q   <= req_addr[2:0];
            wdata_q <= req_wdata;
            data_q  <= '0;
            exc_q   <= 1'b0;
            mis_q   <= 1'b0;
            cnt     <= '0;
            if (is_misaligned(req_len, req_addr[2:0])) begin
              mis_q <= 1'b1;
              state <= S_RESP;
            end else begin
              bus_addr <= {req_addr[63:3], 3'b000};
              if (req_rw && req_len == LEN_D) begin
                data_q <= req_wdata;
                state  <= S_WRITE;
              end else begin
                state <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          if (cnt == CNT_W'(BUS_LATENCY)) begin
            cnt <= '0;
            if (bus_exception) begin
              exc_q  <= 1'b1;
              data_q <= '0;
              state  <= S_RESP;
            end else if (rw_q) begin
              data_q <= st_merged;
              state  <= S_WRITE;
            end else begin
              data_q <= ld_ext;
              state  <= S_RESP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WRITE: begin
          exc_q <= bus_exception;
          state <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready       = (state == S_IDLE);
  assign resp_valid      = (state == S_RESP);
  assign resp_exception  = resp_valid & exc_q;
  assign resp_misaligned = resp_valid & mis_q;
  assign resp_rdata      = (resp_valid && !rw_q) ? data_q : '0;
  assign bus_rw          = (state == S_WRITE);
  assign bus_write       = bus_rw ? data_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit.
// Byte-loop reference model, flat bus responder.
module tb_load_store_unit;

  localparam int L = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [1:0]  req_len;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_exception;
  logic        resp_misaligned;
  logic        bus_rw;
  logic [63:0] bus_addr;
  logic [63:0] bus_write;
  logic [63:0] bus_read;
  logic        bus_exception;

  logic [63:0] mem;
  logic        bexc_rd;
  logic        bexc_wr;

  assign bus_read      = mem;
  assign bus_exception = bus_rw ? bexc_wr : bexc_rd;

  load_store_unit #(.BUS_LATENCY(L)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_rw          (req_rw),
    .req_len         (req_len),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_exception  (resp_exception),
    .resp_misaligned (resp_misaligned),
    .bus_rw          (bus_rw),
    .bus_addr        (bus_addr),
    .bus_write       (bus_write),
    .bus_read        (bus_read),
    .bus_exception   (bus_exception)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        exc;
    logic        mis;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          base = 0;
  int          pulses = 0;
  logic [63:0] last_wr = '0;
  logic [63:0] exp_baddr = '0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_load(
    input logic [63:0] d, input logic [2:0] off,
    input logic [1:0] len, input logic sgn);
    logic [63:0] r;
    int n;
    n = 1 << len;
    r = '0;
    for (int i = 0; i < n; i++)
      r[8*i +: 8] = d[8*(int'(off)+i) +: 8];
    if (sgn && r[8*n-1])
      for (int b = 8*n; b < 64; b++) r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_merge(
    input logic [63:0] d, input logic [63:0] w,
    input logic [2:0] off, input logic [1:0] len);
    logic [63:0] r;
    int n;
    n = 1 << len;
    r = d;
    for (int i = 0; i < n; i++)
      r[8*(int'(off)+i) +: 8] = w[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus_rw === 1'b1) begin
      pulses++;
      last_wr = bus_write;
    end
    if (resp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rdata", resp_rdata, e.rdata);
        chk("exc", 64'(resp_exception), 64'(e.exc));
        chk("mis", 64'(resp_misaligned), 64'(e.mis));
        chk("latency", 64'(cyc - base + 1), 64'(e.lat));
      end
    end
  end

  task automatic drive(input logic rw, input logic [1:0] len,
                       input logic sgn, input logic [63:0] addr,
                       input logic [63:0] wdata);
    @(negedge clk);
    req_rw     = rw;
    req_len    = len;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
  endtask

  task automatic issue(input logic rw, input logic [1:0] len,
                       input logic sgn, input logic [63:0] addr,
                       input logic [63:0] wdata,
                       input logic [63:0] rd,
                       input logic er, input logic ew,
                       input bit hold);
    exp_t        e;
    logic        mis;
    logic        sub;
    logic        wr;
    logic [63:0] exp_w;
    int          n0;
    mis = (addr & ((64'd1 << len) - 64'd1)) != 64'd0;
    sub = (len != 2'd3);
    e.mis = mis;
    e.rdata = '0;
    e.exc = 1'b0;
    if (mis) e.lat = 1;
    else if (!rw) begin
      e.lat = L + 2;
      e.exc = er;
      e.rdata = er ? 64'd0 : m_load(rd, addr[2:0], len, sgn);
    end else if (!sub) begin
      e.lat = 2;
      e.exc = ew;
    end else if (er) begin
      e.lat = L + 2;
      e.exc = 1'b1;
    end else begin
      e.lat = L + 3;
      e.exc = ew;
    end
    wr = rw && !mis && !(sub && er);
    exp_w = sub ? m_merge(rd, wdata, addr[2:0], len) : wdata;
    if (!mis) exp_baddr = {addr[63:3], 3'b000};
    mem = rd;
    bexc_rd = er;
    bexc_wr = ew;
    sbq.push_back(e);
    n0 = pulses;
    drive(rw, len, sgn, addr, wdata);
    if (hold) req_addr = addr + 64'h100;
    else req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (i == 1) req_valid = 1'b0;
      if (sbq.size() == 0) break;
    end
    req_valid = 1'b0;
    if (sbq.size() != 0) begin
      chk("timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    chk("bus_pulses", 64'(pulses - n0), wr ? 64'd1 : 64'd0);
    if (wr) chk("bus_write", last_wr, exp_w);
    chk("bus_addr", bus_addr, exp_baddr);
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_rw = 1'b0;
    req_len = 2'd0;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    mem = '0;
    bexc_rd = 1'b0;
    bexc_wr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_exc", 64'(resp_exception), 64'd0);
    chk("rst_mis", 64'(resp_misaligned), 64'd0);
    chk("rst_rw", 64'(bus_rw), 64'd0);
    chk("rst_addr", bus_addr, 64'd0);
    chk("rst_write", bus_write, 64'd0);
    rst = 1'b0;

    issue(0, 2'd0, 1, 64'h1005, 0,
          64'h0000_80FF_0000_0000, 0, 0, 0);
    issue(0, 2'd0, 1, 64'h1004, 0,
          64'h0000_80FF_0000_0000, 0, 0, 0);
    issue(0, 2'd1, 0, 64'h200A, 0,
          64'h1111_2222_8765_4444, 0, 0, 0);
    issue(0, 2'd2, 1, 64'h3004, 0,
          64'h9ABC_DEF0_1234_5678, 0, 0, 0);
    issue(0, 2'd3, 0, 64'h4000, 0,
          64'hFEDC_BA98_7654_3210, 0, 0, 1);
    issue(1, 2'd1, 0, 64'h1002, 64'hABCD,
          64'h1111_2222_3333_4444, 0, 0, 0);
    issue(1, 2'd3, 0, 64'h5008, 64'hDEAD_BEEF_0BAD_F00D,
          64'h0, 0, 0, 0);
    issue(1, 2'd0, 0, 64'h5003, 64'hFFFF_FFFF_FFFF_FF5A,
          64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    issue(1, 2'd2, 0, 64'h5004, 64'h0123_4567_89AB_CDEF,
          64'h5555_5555_5555_5555, 0, 0, 0);
    issue(0, 2'd2, 0, 64'h1006, 0,
          64'h1234_5678_9ABC_DEF0, 0, 0, 0);
    issue(1, 2'd3, 0, 64'h6004, 64'h1, 64'h0, 0, 0, 0);
    issue(1, 2'd1, 0, 64'h1002, 64'hABCD,
          64'h1111_2222_3333_4444, 1, 0, 0);
    issue(0, 2'd2, 0, 64'h7000, 0,
          64'h7777_7777_7777_7777, 1, 0, 0);
    issue(1, 2'd3, 0, 64'h7008, 64'h42, 64'h0, 0, 1, 0);

    mem = 64'h1111_2222_3333_4444;
    bexc_rd = 1'b0;
    bexc_wr = 1'b0;
    n0 = pulses;
    drive(1, 2'd1, 0, 64'h1002, 64'hABCD);
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_rw", 64'(bus_rw), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_pulses", 64'(pulses - n0), 64'd0);
    chk("abort_ready2", 64'(req_ready), 64'd1);
    chk("abort_addr", bus_addr, 64'd0);
    issue(0, 2'd3, 1, 64'h8000, 0,
          64'h8000_0000_0000_0001, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
